// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU/PC/operand
// selects, FSM state encoding and the decoded control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States whose exit into FETCH retires an instruction.
  function automatic logic retires(input state_e s);
    case (s)
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retires = 1'b1;
      default:                                               retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/mem_ready in, control word out.
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 2
);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                branch_ne;
  logic [1:0]          pc_source;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_2_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                instr_done;
  logic                illegal;

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational state -> control-word decode. Only FETCH looks at mem_ready,
// so the IR and PC load exactly on the cycle the fetch completes.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   is_bne_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BOFF;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_2_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_WB: ctrl_o.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = is_bne_i;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing, lw/sw and
// beq/bne latches, sticky illegal flag and the retire pulse.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_BNE  = 1'b1,
  parameter int ALU_OP_W    = 2
) (
  input logic                      clk,
  input logic                      arst,
  multicycle_control_unit_if.slave bus
);

  state_e state_q, state_d;
  logic   is_lw_q, is_lw_d;
  logic   is_bne_q, is_bne_d;
  logic   illegal_q, illegal_d;
  logic   done_q, done_d;
  ctrl_t  ctrl_s;

  // Next-state sequencing; the opcode is only consulted in DECODE.
  always_comb begin
    state_d  = state_q;
    is_lw_d  = is_lw_q;
    is_bne_d = is_bne_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
      S_DECODE: begin
        is_lw_d  = (bus.opcode == OP_LW);
        is_bne_d = (bus.opcode == OP_BNE);
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       if (ENABLE_BNE) state_d = S_BRANCH; else state_d = S_TRAP;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      if (ENABLE_ADDI) state_d = S_I_EXEC; else state_d = S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: if (is_lw_q) state_d = S_MEM_RD; else state_d = S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB; else state_d = S_MEM_RD;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH; else state_d = S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RST;
    endcase
    illegal_d = (state_d == S_TRAP);
    done_d    = retires(state_q) && (state_d == S_FETCH);
  end

  // State and status registers; reset forces RST so every output drops at once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_RST;
      is_lw_q   <= 1'b0;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_lw_q   <= is_lw_d;
      is_bne_q  <= is_bne_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .is_bne_i    (is_bne_q),
    .ctrl_o      (ctrl_s)
  );

  assign bus.pc_write      = ctrl_s.pc_write;
  assign bus.pc_write_cond = ctrl_s.pc_write_cond;
  assign bus.branch_ne     = ctrl_s.branch_ne;
  assign bus.pc_source     = ctrl_s.pc_source;
  assign bus.i_or_d        = ctrl_s.i_or_d;
  assign bus.mem_read      = ctrl_s.mem_read;
  assign bus.mem_write     = ctrl_s.mem_write;
  assign bus.ir_write      = ctrl_s.ir_write;
  assign bus.mem_2_reg     = ctrl_s.mem_2_reg;
  assign bus.reg_dst       = ctrl_s.reg_dst;
  assign bus.reg_write     = ctrl_s.reg_write;
  assign bus.alu_src_a     = ctrl_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_s.alu_src_b;
  assign bus.instr_done    = done_q;
  assign bus.illegal       = illegal_q;

  // Widen the 2-bit ALU code; upper bits are always zero.
  always_comb begin
    bus.alu_op      = '0;
    bus.alu_op[1:0] = ctrl_s.alu_op;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each stimulus cycle pushes the expected control word derived
// from the instruction's step sequence; a monitor pops and compares at negedge.
module tb_multicycle_control_unit;

  localparam int AW = 3;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       bne;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [AW-1:0] aop;
    logic       done;
    logic       ill;
  } cw_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic arst2 = 1'b1;
  logic test_end = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_OP_W(AW)) bif ();
  multicycle_control_unit_if #(.ALU_OP_W(2))  bif2 ();

  multicycle_control_unit #(.ENABLE_ADDI(1'b1), .ENABLE_BNE(1'b1), .ALU_OP_W(AW)) dut (
    .clk(clk), .arst(arst), .bus(bif));
  multicycle_control_unit #(.ENABLE_ADDI(1'b0), .ENABLE_BNE(1'b0), .ALU_OP_W(2)) dut2 (
    .clk(clk), .arst(arst2), .bus(bif2));

  cw_t act, act2;
  assign act = {bif.pc_write, bif.pc_write_cond, bif.branch_ne, bif.pc_source, bif.i_or_d,
                bif.mem_read, bif.mem_write, bif.ir_write, bif.mem_2_reg, bif.reg_dst,
                bif.reg_write, bif.alu_src_a, bif.alu_src_b, bif.alu_op, bif.instr_done,
                bif.illegal};
  assign act2 = {bif2.pc_write, bif2.pc_write_cond, bif2.branch_ne, bif2.pc_source, bif2.i_or_d,
                 bif2.mem_read, bif2.mem_write, bif2.ir_write, bif2.mem_2_reg, bif2.reg_dst,
                 bif2.reg_write, bif2.alu_src_a, bif2.alu_src_b, 1'b0, bif2.alu_op,
                 bif2.instr_done, bif2.illegal};

  cw_t   exp_q[$];
  string tag_q[$];
  bit    sel_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    done_pend[2];

  // Monitor: one expected word per cycle, compared mid-cycle.
  initial begin
    cw_t e_m, a_m;
    string t_m;
    bit s_m;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e_m = exp_q.pop_front();
        t_m = tag_q.pop_front();
        s_m = sel_q.pop_front();
        a_m = s_m ? act2 : act;
        n_checks++;
        if (a_m !== e_m) begin
          n_fail++;
          $display("FAIL %s (dut%0d) @%0t: actual %b required %b", t_m, s_m, $time, a_m, e_m);
        end
      end
    end
  end

  // Watchdog: the whole sequence must complete within a bounded time.
  initial begin
    #(2000000);
    if (!test_end) begin
      n_fail++;
      $display("FAIL watchdog @%0t: test did not complete in time", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic check_now(input cw_t a, input cw_t e, input string tag);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %b required %b", tag, $time, a, e);
    end
  endtask

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic logic [5:0] rnd6();
    logic [31:0] r;
    r = $urandom;
    return r[5:0];
  endfunction

  // Which opcodes each configuration accepts (dut1: everything, dut2: no addi/bne).
  function automatic bit legal(input bit sel, input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h04, 6'h23, 6'h2B: return 1'b1;
      6'h05, 6'h08:                      return !sel;
      default:                           return 1'b0;
    endcase
  endfunction

  task automatic step(input bit sel, input logic [5:0] op, input logic rdy, input logic rst,
                      input cw_t e, input string tag);
    @(posedge clk);
    #1;
    if (sel) begin
      bif2.opcode = op; bif2.mem_ready = rdy; arst2 = rst;
    end else begin
      bif.opcode = op; bif.mem_ready = rdy; arst = rst;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
  endtask

  task automatic reset_seq(input bit sel, input int n);
    cw_t e;
    e = '0;
    for (int i = 0; i < n; i++) step(sel, rnd6(), rbit(), 1'b1, e, "reset_hold");
    step(sel, rnd6(), rbit(), 1'b0, e, "reset_release");
    done_pend[sel] = 1'b0;
  endtask

  task automatic fetch(input bit sel, input int fwait);
    cw_t e;
    for (int i = 0; i <= fwait; i++) begin
      e = '0;
      e.mrd  = 1'b1;
      e.asb  = 2'b01;
      e.irw  = (i == fwait);
      e.pcw  = (i == fwait);
      e.done = (i == 0) && done_pend[sel];
      step(sel, rnd6(), (i == fwait), 1'b0, e, "fetch");
    end
    done_pend[sel] = 1'b0;
  endtask

  // Waits mwait not-ready cycles then one ready cycle in a memory access step.
  task automatic mem_wait(input bit sel, input int mwait, input cw_t e, input string tag);
    for (int i = 0; i <= mwait; i++) step(sel, rnd6(), (i == mwait), 1'b0, e, tag);
  endtask

  task automatic run_instr(input bit sel, input logic [5:0] op, input int fwait,
                           input int mwait, input int tcyc);
    cw_t e;
    fetch(sel, fwait);
    e = '0;
    e.asb = 2'b11;
    step(sel, op, rbit(), 1'b0, e, "decode");
    if (!legal(sel, op)) begin
      e = '0;
      e.ill = 1'b1;
      for (int i = 0; i < tcyc; i++) step(sel, rnd6(), rbit(), 1'b0, e, "trap");
      reset_seq(sel, 1);
    end else if (op == 6'h00 || op == 6'h08) begin
      e = '0;
      e.asa = 1'b1;
      e.asb = (op == 6'h00) ? 2'b00 : 2'b10;
      e.aop = (op == 6'h00) ? 3'd2 : 3'd0;
      step(sel, rnd6(), rbit(), 1'b0, e, "exec");
      e = '0;
      e.rw   = 1'b1;
      e.rdst = (op == 6'h00);
      step(sel, rnd6(), rbit(), 1'b0, e, "writeback");
      done_pend[sel] = 1'b1;
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = '0;
      e.asa = 1'b1;
      e.asb = 2'b10;
      step(sel, rnd6(), rbit(), 1'b0, e, "mem_addr");
      e = '0;
      e.iord = 1'b1;
      if (op == 6'h23) begin
        e.mrd = 1'b1;
        mem_wait(sel, mwait, e, "mem_read");
        e = '0;
        e.rw  = 1'b1;
        e.m2r = 1'b1;
        step(sel, rnd6(), rbit(), 1'b0, e, "mem_wb");
      end else begin
        e.mwr = 1'b1;
        mem_wait(sel, mwait, e, "mem_write");
      end
      done_pend[sel] = 1'b1;
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0;
      e.asa  = 1'b1;
      e.aop  = 3'd1;
      e.pcwc = 1'b1;
      e.pcs  = 2'b01;
      e.bne  = (op == 6'h05);
      step(sel, rnd6(), rbit(), 1'b0, e, "branch");
      done_pend[sel] = 1'b1;
    end else begin
      e = '0;
      e.pcw = 1'b1;
      e.pcs = 2'b10;
      step(sel, rnd6(), rbit(), 1'b0, e, "jump");
      done_pend[sel] = 1'b1;
    end
  endtask

  logic [5:0] legal_tab [7];
  initial begin
    cw_t e;
    cw_t z;
    logic [5:0] op;
    int r;
    z = '0;
    legal_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
    bif.opcode = 6'h00;  bif.mem_ready = 1'b0;
    bif2.opcode = 6'h00; bif2.mem_ready = 1'b0;
    done_pend[0] = 1'b0;
    done_pend[1] = 1'b0;

    reset_seq(1'b0, 2);
    // lw stalled in MEM_RD, then reset mid-wait
    fetch(1'b0, 0);
    e = '0; e.asb = 2'b11;
    step(1'b0, 6'h23, 1'b1, 1'b0, e, "decode");
    e = '0; e.asa = 1'b1; e.asb = 2'b10;
    step(1'b0, rnd6(), 1'b1, 1'b0, e, "mem_addr");
    e = '0; e.mrd = 1'b1; e.iord = 1'b1;
    step(1'b0, rnd6(), 1'b0, 1'b0, e, "mem_read_wait");
    step(1'b0, rnd6(), 1'b0, 1'b0, e, "mem_read_wait");
    step(1'b0, rnd6(), 1'b0, 1'b1, z, "reset_hold");
    #1;
    check_now(act, z, "async_reset_state");
    step(1'b0, rnd6(), rbit(), 1'b0, z, "reset_release");
    #1;
    check_now(act, z, "reset_release_state");
    done_pend[0] = 1'b0;

    run_instr(1'b0, 6'h00, 0, 0, 0);
    run_instr(1'b0, 6'h23, 0, 0, 0);
    run_instr(1'b0, 6'h2B, 0, 3, 0);
    run_instr(1'b0, 6'h05, 0, 0, 0);
    run_instr(1'b0, 6'h04, 1, 0, 0);
    run_instr(1'b0, 6'h02, 2, 0, 0);
    run_instr(1'b0, 6'h08, 0, 0, 0);
    run_instr(1'b0, 6'h3F, 0, 0, 10);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(39, 0);
      if (r < 35)      op = legal_tab[r % 7];
      else if (r < 38) op = rnd6();
      else             op = 6'h3F;
      run_instr(1'b0, op, $urandom_range(2, 0), $urandom_range(3, 0), 3);
    end

    reset_seq(1'b1, 2);
    run_instr(1'b1, 6'h05, 0, 0, 20);
    run_instr(1'b1, 6'h08, 1, 0, 5);
    run_instr(1'b1, 6'h04, 0, 0, 0);
    run_instr(1'b1, 6'h00, 0, 0, 0);
    run_instr(1'b1, 6'h23, 1, 2, 0);

    @(negedge clk);
    @(negedge clk);
    test_end = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
